// File: rtl/nor_seq_pkg.sv
// nor_seq_pkg: shared types and helpers for the NOR-sequencing arbiter.
// States, opcode encodings and the opcode -> NOR pass count mapping.
package nor_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P2   = 3'd2,
        ST_P3   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_NOR = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // Number of sequential NOR passes needed to build each operation.
    function automatic logic [1:0] pass_count(input logic [1:0] opc);
        logic [1:0] n;
        case (opc)
            OP_OR:   n = 2'd2;
            OP_AND:  n = 2'd3;
            default: n = 2'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/nor_word.sv
// nor_word: the single shared W-bit NOR evaluation unit (purely combinational).
module nor_word #(
    parameter int W = 8
) (
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    output logic [W-1:0] y
);

    assign y = ~(x0 | x1);

endmodule

// File: rtl/nor_seq_arbiter.sv
// nor_seq_arbiter: round-robin arbiter that sequences NOT/NOR/OR/AND requests
// through one shared NOR unit, one operation in flight at a time.
// Optional build macro NOR_SEQ_STATS_EN adds a saturating 16-bit op_count output.
module nor_seq_arbiter
    import nor_seq_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [2*N_REQ-1:0]       op,
    input  logic [N_REQ*W-1:0]       a,
    input  logic [N_REQ*W-1:0]       b,
    output logic [N_REQ-1:0]         gnt,
    output logic                     done,
    output logic [W-1:0]             result,
    output logic [$clog2(N_REQ)-1:0] done_id
`ifdef NOR_SEQ_STATS_EN
    ,
    output logic [15:0]              op_count
`endif
);

    localparam int IDW = $clog2(N_REQ);

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [1:0]       r_op;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_t0;
    logic [W-1:0]     r_t1;
    logic [W-1:0]     r_result;
    logic [N_REQ-1:0] r_gnt;
    logic             r_done;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [IDW:0]     w_pick;
    logic [W-1:0]     w_x0;
    logic [W-1:0]     w_x1;
    logic [W-1:0]     w_y;

    logic [1:0]       w_op_arr [N_REQ];
    logic [W-1:0]     w_a_arr  [N_REQ];
    logic [W-1:0]     w_b_arr  [N_REQ];

    // Unpack the flat per-requester buses so the winner can be indexed directly.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_op_arr[g] = op[2*g +: 2];
        assign w_a_arr[g]  = a[W*g +: W];
        assign w_b_arr[g]  = b[W*g +: W];
    end

    // First set request bit scanning upward from p, wrapping; MSB flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] rq,
                                             input logic [IDW-1:0]   p);
        logic [IDW:0] res;
        int           j;
        res = '0;
        // Scan downward so the candidate closest to the pointer is written last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(p) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (rq[j[IDW-1:0]]) res = {1'b1, j[IDW-1:0]};
        end
        return res;
    endfunction

    assign w_pick  = rr_pick(req, r_ptr);
    assign w_found = w_pick[IDW];
    assign w_win   = w_pick[IDW-1:0];

    nor_word #(.W(W)) u_nor (
        .x0 (w_x0),
        .x1 (w_x1),
        .y  (w_y)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and NOR operand mux per pass.
    always_comb begin
        w_next = r_state;
        w_x0   = '0;
        w_x1   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) w_next = ST_P1;
            end
            ST_P1: begin
                w_x0 = r_a;
                case (r_op)
                    OP_NOT:  w_x1 = '0;
                    OP_AND:  w_x1 = r_a;    // t0 = ~a
                    default: w_x1 = r_b;    // NOR result, or t0 for OR
                endcase
                w_next = (pass_count(r_op) == 2'd1) ? ST_DONE : ST_P2;
            end
            ST_P2: begin
                if (pass_count(r_op) == 2'd2) begin
                    w_x0   = r_t0;          // OR: invert the NOR
                    w_x1   = '0;
                    w_next = ST_DONE;
                end else begin
                    w_x0   = r_b;           // AND: t1 = ~b
                    w_x1   = r_b;
                    w_next = ST_P3;
                end
            end
            ST_P3: begin
                w_x0   = r_t0;              // AND: ~(~a | ~b)
                w_x1   = r_t1;
                w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Grant/operand latch, pass temporaries, result capture and pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_op     <= OP_NOT;
            r_a      <= '0;
            r_b      <= '0;
            r_t0     <= '0;
            r_t1     <= '0;
            r_result <= '0;
            r_gnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_op  <= w_op_arr[w_win];
                        r_a   <= w_a_arr[w_win];
                        r_b   <= w_b_arr[w_win];
                        r_gnt <= N_REQ'(1) << w_win;
                        r_id  <= w_win;
                    end
                end
                ST_P1, ST_P2, ST_P3: begin
                    if (w_next == ST_DONE) begin
                        r_result <= w_y;
                        r_done   <= 1'b1;
                    end else if (r_state == ST_P1) begin
                        r_t0 <= w_y;
                    end else begin
                        r_t1 <= w_y;
                    end
                end
                ST_DONE: begin
                    r_gnt <= '0;
                    r_ptr <= (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef NOR_SEQ_STATS_EN
    logic [15:0] r_op_count;

    // Saturating count of completed operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_op_count <= '0;
        else if (r_state == ST_DONE && r_op_count != 16'hFFFF)
            r_op_count <= r_op_count + 16'd1;
    end

    assign op_count = r_op_count;
`endif

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign result  = r_result;
    assign done_id = r_id;

endmodule

// File: tb/tb_nor_seq_arbiter.sv
// tb_nor_seq_arbiter: directed self-checking bench for nor_seq_arbiter (N_REQ=4, W=8).
module tb_nor_seq_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  gnt;
    logic        done;
    logic [7:0]  result;
    logic [1:0]  done_id;
`ifdef NOR_SEQ_STATS_EN
    logic [15:0] op_count;
`endif

    int checks = 0;
    int errors = 0;

    nor_seq_arbiter #(.N_REQ(4), .W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op      (op),
        .a       (a),
        .b       (b),
        .gnt     (gnt),
        .done    (done),
        .result  (result),
        .done_id (done_id)
`ifdef NOR_SEQ_STATS_EN
        ,
        .op_count(op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, wait (bounded) for done, drop req and return to IDLE.
    // lat counts posedges from the sampling edge E0 to done; -1 on timeout.
    task automatic do_op(input int idx, input logic [1:0] opc,
                         input logic [7:0] av, input logic [7:0] bv,
                         output logic [7:0] res, output int id,
                         output int lat, output logic [3:0] g0);
        @(negedge clk);
        op[2*idx +: 2] = opc;
        a[8*idx +: 8]  = av;
        b[8*idx +: 8]  = bv;
        req[idx]       = 1'b1;
        @(posedge clk); @(negedge clk);
        g0  = gnt;
        lat = 1;
        res = '0;
        id  = -1;
        while (!done && lat < 10) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        if (done) begin
            res = result;
            id  = int'(done_id);
        end else begin
            lat = -1;
        end
        req[idx] = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = '0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
        checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL reset_done_id: got %0d expected 0", done_id); end
`ifdef NOR_SEQ_STATS_EN
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_not;
        logic [7:0] res; int id, lat; logic [3:0] g0;
        do_op(0, 2'b00, 8'hA5, 8'h00, res, id, lat, g0);
        checks++; if (g0 !== 4'b0001) begin errors++; $display("FAIL not_gnt: got %b expected 0001", g0); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL not_latency: got %0d expected 2", lat); end
        checks++; if (res !== 8'h5A) begin errors++; $display("FAIL not_result: got %h expected 5a", res); end
        checks++; if (id !== 0) begin errors++; $display("FAIL not_done_id: got %0d expected 0", id); end
        checks++; if (gnt !== 4'b0000 || done !== 1'b0) begin errors++; $display("FAIL not_release: got gnt=%b done=%b expected 0000/0", gnt, done); end
    endtask

    task automatic test_and;
        logic [7:0] res; int id, lat; logic [3:0] g0;
        do_op(2, 2'b11, 8'hF0, 8'h3C, res, id, lat, g0);
        checks++; if (g0 !== 4'b0100) begin errors++; $display("FAIL and_gnt: got %b expected 0100", g0); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL and_latency: got %0d expected 4", lat); end
        checks++; if (res !== 8'h30) begin errors++; $display("FAIL and_result: got %h expected 30", res); end
        checks++; if (id !== 2) begin errors++; $display("FAIL and_done_id: got %0d expected 2", id); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL and_release: got %b expected 0000", gnt); end
    endtask

    task automatic test_or_nor;
        logic [7:0] res; int id, lat; logic [3:0] g0;
        do_op(1, 2'b10, 8'h0F, 8'h30, res, id, lat, g0);
        checks++; if (g0 !== 4'b0010) begin errors++; $display("FAIL or_gnt: got %b expected 0010", g0); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL or_latency: got %0d expected 3", lat); end
        checks++; if (res !== 8'h3F) begin errors++; $display("FAIL or_result: got %h expected 3f", res); end
        do_op(3, 2'b01, 8'h0F, 8'h30, res, id, lat, g0);
        checks++; if (lat !== 2) begin errors++; $display("FAIL nor_latency: got %0d expected 2", lat); end
        checks++; if (res !== 8'hC0) begin errors++; $display("FAIL nor_result: got %h expected c0", res); end
        checks++; if (id !== 3) begin errors++; $display("FAIL nor_done_id: got %0d expected 3", id); end
    endtask

    // All four requesters held with NOT ops; each drops after its done and
    // re-raises one cycle later, so grants must walk round-robin from 'first'.
    task automatic rr_round(input int first);
        logic [7:0] av [4];
        logic [7:0] ev [4];
        int k, lat, exp_id;
        av = '{8'h12, 8'h34, 8'h56, 8'h78};
        ev = '{8'hED, 8'hCB, 8'hA9, 8'h87};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            op[2*i +: 2] = 2'b00;
            a[8*i +: 8]  = av[i];
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_id = (first + n) % 4;
            lat = 0;
            while (!done && lat < 12) begin
                @(posedge clk); @(negedge clk);
                lat++;
            end
            checks++;
            if (!done || int'(done_id) !== exp_id) begin
                errors++;
                $display("FAIL rr_order: grant %0d got id %0d done=%b expected id %0d", n, done_id, done, exp_id);
            end
            checks++;
            if (result !== ev[exp_id]) begin
                errors++;
                $display("FAIL rr_result: grant %0d got %h expected %h", n, result, ev[exp_id]);
            end
            k = done ? int'(done_id) : exp_id;
            req[k] = 1'b0;
            @(posedge clk); @(negedge clk);
            if (n < 4) req[k] = 1'b1;
            else       req = '0;
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [7:0] res; int id, lat; logic [3:0] g0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_round(0);
        // Serving requester 2 alone moves the pointer to 3.
        do_op(2, 2'b00, 8'hFF, 8'h00, res, id, lat, g0);
        checks++; if (res !== 8'h00 || id !== 2) begin errors++; $display("FAIL rr_setup: got res=%h id=%0d expected 00/2", res, id); end
        rr_round(3);
    endtask

    task automatic test_operand_stability;
        int lat;
        @(negedge clk);
        op[7:6] = 2'b11; a[31:24] = 8'hCC; b[31:24] = 8'hAA; req[3] = 1'b1;
        @(posedge clk); @(negedge clk);        // P1
        @(posedge clk); @(negedge clk);        // P2
        req[3] = 1'b0; op[7:6] = 2'b00; a[31:24] = 8'h00; b[31:24] = 8'h00;
        lat = 0;
        while (!done && lat < 10) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        checks++; if (done !== 1'b1 || lat !== 2) begin errors++; $display("FAIL stab_done: got done=%b after %0d cycles expected 1 after 2", done, lat); end
        checks++; if (result !== 8'h88) begin errors++; $display("FAIL stab_result: got %h expected 88", result); end
        checks++; if (done_id !== 2'd3 || gnt !== 4'b1000) begin errors++; $display("FAIL stab_id: got id=%0d gnt=%b expected 3/1000", done_id, gnt); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        int lat;
        logic [3:0] g0;
        @(negedge clk);
        op[1:0] = 2'b11; a[7:0] = 8'hFF; b[7:0] = 8'hFF; req[0] = 1'b1;
        @(posedge clk); @(negedge clk);        // P1
        @(posedge clk); @(negedge clk);        // P2
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000 || done !== 1'b0) begin errors++; $display("FAIL rst_mid: got gnt=%b done=%b expected 0000/0", gnt, done); end
        op[1:0] = 2'b00; a[7:0] = 8'h3C;
        @(posedge clk); @(negedge clk);
        checks++; if (done !== 1'b0 || result !== 8'h00) begin errors++; $display("FAIL rst_hold: got done=%b result=%h expected 0/00", done, result); end
`ifdef NOR_SEQ_STATS_EN
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL rst_op_count: got %0d expected 0", op_count); end
`endif
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        g0 = gnt;
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        checks++; if (g0 !== 4'b0001) begin errors++; $display("FAIL rst_regrant: got %b expected 0001", g0); end
        checks++; if (done !== 1'b1 || lat !== 2 || result !== 8'hC3) begin errors++; $display("FAIL rst_after: got done=%b lat=%0d result=%h expected 1/2/c3", done, lat, result); end
        req[0] = 1'b0;
        @(posedge clk); @(negedge clk);
`ifdef NOR_SEQ_STATS_EN
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL rst_op_count_after: got %0d expected 1", op_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_not();
        test_and();
        test_or_nor();
        test_round_robin();
        test_operand_stability();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nor_seq_arbiter.md
# nor_seq_arbiter

Round-robin arbiter and sequencer that shares one word-wide NOR evaluation unit between up to N_REQ requesters. It builds NOT, NOR, OR and AND out of one to three sequential NOR passes through the shared unit, so NOR stays the single universal primitive in the design. One operation is in flight at a time. The requester holds the grant until its result is returned with a one-cycle `done` pulse.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `W`, default 8: operand and result width.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  N_REQ: per-requester request level.
- `op`  in  2*N_REQ: opcode for requester i, in bits [2i+1:2i].
  - 00 = NOT a
  - 01 = NOR(a,b)
  - 10 = OR(a,b)
  - 11 = AND(a,b)
- `a`  in  N_REQ*W: operand A for requester i, in bits [W*i+W-1:W*i].
- `b`  in  N_REQ*W: operand B, sliced the same way as `a`.
- `gnt`  out  N_REQ: one-hot grant; all zero when idle.
- `done`  out  1: one-cycle result-valid strobe.
- `result`  out  W: operation result; valid while `done` is high.
- `done_id`  out  $clog2(N_REQ): index of the requester being served.

## Operation
- States: IDLE, P1, P2, P3, DONE.
- Reset values:
  - state = IDLE, priority pointer `ptr` = 0.
  - `gnt` = 0, `done` = 0, `result` = 0, `done_id` = 0.
  - Internal temporaries t0 and t1 = 0.
- IDLE:
  - If `req` is nonzero, the winner is the first set bit scanning upward from `ptr`, with wrap-around.
  - Register the winner's `op`, `a` and `b`, assert its `gnt` bit, load `done_id`, and go to P1.
  - If `req` is zero, stay in IDLE.
- Pass schedule (each pass is one cycle through the shared NOR unit; the result register takes the last pass):
  - NOT: P1 computes nor(a,0). Then go to DONE.
  - NOR: P1 computes nor(a,b). Then go to DONE.
  - OR: P1 computes t0 = nor(a,b). P2 computes nor(t0,0). Then go to DONE.
  - AND: P1 computes t0 = nor(a,a). P2 computes t1 = nor(b,b). P3 computes nor(t0,t1). Then go to DONE.
- DONE:
  - `done` = 1 and `gnt` is held.
  - `ptr` ← (winner+1) mod N_REQ.
  - Next state is IDLE, where `gnt` clears.
- Operands are latched at grant. Changes to `op`, `a` or `b` after grant have no effect.
- A winner that drops `req` mid-operation does not abort it: the operation completes and `done` still pulses.
- New or other requests during P1..DONE wait. They are evaluated in the next IDLE cycle.
- A requester must deassert `req` by the cycle after `done`. A request still held when IDLE samples it is treated as a new request.
- Reset asserted mid-operation: all state returns to reset values immediately. No `done` is produced.

## Timing
- Grant: `gnt` rises at the edge that samples `req` in IDLE (edge E0).
- Latency from grant to `done`:
  - NOT and NOR: 1 cycle (`done` high between E1 and E2).
  - OR: 2 cycles.
  - AND: 3 cycles.
- Occupancy per operation, including the IDLE arbitration cycle: passes + 2 cycles. Maximum throughput for AND is one operation per 5 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `NOR_SEQ_STATS_EN` defined:
  - Adds output `op_count` (16 bits), a saturating count of completed operations. It increments in every DONE cycle, holds at 16'hFFFF, and resets to 0.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package `nor_seq_pkg`:
  - State enum.
  - Opcode constants OP_NOT, OP_NOR, OP_OR, OP_AND.
  - Pass-count function mapping opcode to 1/1/2/3.
- Sub-module `nor_word`: parameter W; purely combinational W-bit `y = ~(x0 | x1)`. It is instantiated once and its operands are muxed by state.
- The round-robin pick is a function or always block inside the top module.

## Test plan
- NOT: N_REQ=4, W=8; req=4'b0001, op0=00, a0=8'hA5 → gnt=4'b0001 after E0; done one cycle later with result=8'h5A, done_id=0.
- AND: req=4'b0100, op2=11, a2=8'hF0, b2=8'h3C → result=8'h30; done 3 cycles after gnt.
- OR then NOR: OR with a=8'h0F, b=8'h30 gives 8'h3F with 2-cycle latency. NOR with a=8'h0F, b=8'h30 gives 8'hC0.
- Round-robin fairness: req=4'b1111 held, each requester dropping after its own done → grant order 0,1,2,3,0. Repeat with ptr starting at 3 → order 3,0,1,2.
- Operand stability: req3 drops and a3 is changed during P2 of an AND → done still pulses with the result computed from the latched operands.
- Reset during P2: assert rst_n=0 → gnt=0, done stays 0. After release, a pending req0 is granted normally; with NOR_SEQ_STATS_EN defined, op_count=0.
